os_pe_array: RTL and testbench

- Parametrised output-stationary PE array core. It is the next generation of the output-dataflow core, with a configurable NUM_ROWS x NUM_COLS grid.
- Per-row input vectors and per-column weight vectors are streamed in, internally skewed, and multiply-accumulated in place over a programmable reduction length K.
- The finished tile is then drained row by row over a valid/ready port.
- Sits between the input/weight memory read path (upstream) and the GLB write path (downstream).

---
 rtl/os_pe_array.sv | 197 +++++++++++++++++++
 tb/tb_os_pe_array.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/os_pe_array.sv
// rtl/os_pe_array.sv - output-stationary NUM_ROWS x NUM_COLS PE array core
// Skewed row inputs and column weights accumulate in place over K steps; the tile drains row by row.
module os_pe_array #(
  parameter int NUM_ROWS  = 4,
  parameter int NUM_COLS  = 4,
  parameter int IN_WIDTH  = 8,
  parameter int WT_WIDTH  = 8,
  parameter int ACC_WIDTH = 24,
  parameter int K_WIDTH   = 8
) (
  input  logic                                                  w_clock,
  input  logic                                                  w_reset_n,
  input  logic                                                  w_start,
  input  logic [K_WIDTH-1:0]                                    w_k_len,
  output logic                                                  w_busy,
  input  logic                                                  w_in_valid,
  output logic                                                  w_in_ready,
  input  logic [NUM_ROWS*IN_WIDTH-1:0]                          w_in_data,
  input  logic [NUM_COLS*WT_WIDTH-1:0]                          w_wt_data,
  output logic                                                  w_out_valid,
  input  logic                                                  w_out_ready,
  output logic [NUM_COLS*ACC_WIDTH-1:0]                         w_out_data,
  output logic [((NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1)-1:0]    w_out_row,
  output logic                                                  w_out_last,
  output logic                                                  w_done
);

  localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int FLUSH_N = NUM_ROWS + NUM_COLS - 2;
  localparam int FL_W    = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;
  localparam int PROD_W  = IN_WIDTH + WT_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [K_WIDTH-1:0] r_k_rem;
  logic [FL_W-1:0]    r_flush_cnt;
  logic [ROW_W-1:0]   r_row;
  logic               r_done;

  logic w_start_acc, w_in_hs, w_out_hs, w_last_row, w_flush_end, w_adv, w_clear;

  assign w_start_acc = (r_state == S_IDLE) && w_start;
  assign w_in_hs     = (r_state == S_LOAD) && w_in_valid;
  assign w_out_hs    = (r_state == S_DRAIN) && w_out_ready;
  assign w_last_row  = (r_row == ROW_W'(NUM_ROWS - 1));
  assign w_flush_end = (r_flush_cnt == FL_W'(FLUSH_N - 1));
  assign w_adv       = w_in_hs || (r_state == S_FLUSH);
  assign w_clear     = !w_reset_n || w_start_acc;

  always_ff @(posedge w_clock) begin
    if (!w_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_busy      = 1'b1;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_start) w_next = (w_k_len == '0) ? S_DRAIN : S_LOAD;
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (w_in_hs && (r_k_rem == K_WIDTH'(1))) w_next = (FLUSH_N == 0) ? S_DRAIN : S_FLUSH;
      end
      S_FLUSH: begin
        if (w_flush_end) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_out_valid = 1'b1;
        w_out_last  = w_last_row;
        if (w_out_hs && w_last_row) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clock) begin
    if (!w_reset_n) begin
      r_k_rem     <= '0;
      r_flush_cnt <= '0;
      r_row       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_out_hs && w_last_row;
      if (w_start_acc) begin
        r_k_rem     <= w_k_len;
        r_flush_cnt <= '0;
        r_row       <= '0;
      end
      if (w_in_hs) r_k_rem <= r_k_rem - K_WIDTH'(1);
      if (r_state == S_FLUSH) r_flush_cnt <= r_flush_cnt + FL_W'(1);
      if (w_out_hs) r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
    end
  end

  // Array edges see live data only in LOAD; FLUSH pushes zeros through the skew.
  logic        [IN_WIDTH-1:0]  w_a_edge [NUM_ROWS];
  logic        [WT_WIDTH-1:0]  w_w_edge [NUM_COLS];
  logic        [IN_WIDTH-1:0]  r_skew_a [NUM_ROWS][NUM_ROWS];
  logic        [WT_WIDTH-1:0]  r_skew_w [NUM_COLS][NUM_COLS];
  logic        [IN_WIDTH-1:0]  w_a_op   [NUM_ROWS][NUM_COLS];
  logic        [WT_WIDTH-1:0]  w_w_op   [NUM_ROWS][NUM_COLS];
  logic        [IN_WIDTH-1:0]  r_a_fwd  [NUM_ROWS][NUM_COLS];
  logic        [WT_WIDTH-1:0]  r_w_fwd  [NUM_ROWS][NUM_COLS];
  logic signed [PROD_W-1:0]    w_prod   [NUM_ROWS][NUM_COLS];
  logic signed [ACC_WIDTH-1:0] r_acc    [NUM_ROWS][NUM_COLS];

  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      w_a_edge[r] = (r_state == S_LOAD) ? w_in_data[r*IN_WIDTH +: IN_WIDTH] : '0;
    end
    for (int c = 0; c < NUM_COLS; c++) begin
      w_w_edge[c] = (r_state == S_LOAD) ? w_wt_data[c*WT_WIDTH +: WT_WIDTH] : '0;
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      if (c == 0) begin : g_a_left
        if (r == 0) begin : g_a_raw
          assign w_a_op[r][c] = w_a_edge[r];
        end else begin : g_a_skew
          assign w_a_op[r][c] = r_skew_a[r][r-1];
        end
      end else begin : g_a_fwd
        assign w_a_op[r][c] = r_a_fwd[r][c-1];
      end
      if (r == 0) begin : g_w_top
        if (c == 0) begin : g_w_raw
          assign w_w_op[r][c] = w_w_edge[c];
        end else begin : g_w_skew
          assign w_w_op[r][c] = r_skew_w[c][c-1];
        end
      end else begin : g_w_fwd
        assign w_w_op[r][c] = r_w_fwd[r-1][c];
      end
      assign w_prod[r][c] = PROD_W'($signed(w_a_op[r][c])) * PROD_W'($signed(w_w_op[r][c]));
    end
  end

  always_ff @(posedge w_clock) begin
    if (w_clear) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int j = 0; j < NUM_ROWS; j++) r_skew_a[r][j] <= '0;
      end
      for (int c = 0; c < NUM_COLS; c++) begin
        for (int j = 0; j < NUM_COLS; j++) r_skew_w[c][j] <= '0;
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          r_a_fwd[r][c] <= '0;
          r_w_fwd[r][c] <= '0;
          r_acc[r][c]   <= '0;
        end
      end
    end else if (w_adv) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        r_skew_a[r][0] <= w_a_edge[r];
        for (int j = 1; j < NUM_ROWS; j++) r_skew_a[r][j] <= r_skew_a[r][j-1];
      end
      for (int c = 0; c < NUM_COLS; c++) begin
        r_skew_w[c][0] <= w_w_edge[c];
        for (int j = 1; j < NUM_COLS; j++) r_skew_w[c][j] <= r_skew_w[c][j-1];
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          r_a_fwd[r][c] <= w_a_op[r][c];
          r_w_fwd[r][c] <= w_w_op[r][c];
          r_acc[r][c]   <= r_acc[r][c] + ACC_WIDTH'(w_prod[r][c]);
        end
      end
    end
  end

  always_comb begin
    w_out_data = '0;
    if (r_state == S_DRAIN) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        w_out_data[c*ACC_WIDTH +: ACC_WIDTH] = r_acc[r_row][c];
      end
    end
  end

  assign w_out_row = r_row;
  assign w_done    = r_done;

endmodule

// File: tb/tb_os_pe_array.sv
// tb/tb_os_pe_array.sv - table-driven self-check of os_pe_array
// Element data per beat is base + row/col step + k step; expected tiles are hand-computed.
module tb_os_pe_array;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int IW = 8;
  localparam int WW = 8;
  localparam int AW = 24;
  localparam int KW = 8;
  localparam int NV = 7;

  logic            clk = 1'b0;
  logic            reset_n, start, busy, in_valid, in_ready;
  logic [KW-1:0]   k_len;
  logic [R*IW-1:0] in_data;
  logic [C*WW-1:0] wt_data;
  logic            out_valid, out_ready, out_last, done;
  logic [C*AW-1:0] out_data;
  logic [1:0]      out_row;

  always #5 clk = ~clk;

  os_pe_array #(.NUM_ROWS(R), .NUM_COLS(C), .IN_WIDTH(IW), .WT_WIDTH(WW),
                .ACC_WIDTH(AW), .K_WIDTH(KW)) dut (
    .w_clock(clk), .w_reset_n(reset_n), .w_start(start), .w_k_len(k_len),
    .w_busy(busy), .w_in_valid(in_valid), .w_in_ready(in_ready),
    .w_in_data(in_data), .w_wt_data(wt_data), .w_out_valid(out_valid),
    .w_out_ready(out_ready), .w_out_data(out_data), .w_out_row(out_row),
    .w_out_last(out_last), .w_done(done)
  );

  typedef struct {
    int k;
    int a0, ar, ak;
    int w0, wc, wk;
    bit bub;
    bit stall;
    logic [R*C-1:0][31:0] exp;
  } vec_t;

  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_bad = 0;
  int   got [R][C];

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic drive_beat(input vec_t v, input int kk);
    for (int r = 0; r < R; r++) in_data[r*IW +: IW] = IW'(v.a0 + v.ar*r + v.ak*kk);
    for (int c = 0; c < C; c++) wt_data[c*WW +: WW] = WW'(v.w0 + v.wc*c + v.wk*kk);
  endtask

  task automatic run_tile(input int vi);
    vec_t v;
    int kk, cyc, beats, dones, t;
    bit stalled;
    logic [C*AW-1:0] held_d;
    logic [1:0] held_r;
    v = vecs[vi];
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(v.k);
    @(negedge clk);
    start = 1'b0;
    kk = 0;
    cyc = 0;
    if (v.k > 0) check($sformatf("v%0d_in_ready_load", vi), in_ready, 1);
    while (kk < v.k && cyc < 2000) begin
      in_valid = v.bub ? (cyc % 2 == 1) : 1'b1;
      if (in_valid) drive_beat(v, kk);
      else begin
        in_data = {R{8'h5A}};
        wt_data = {C{8'hA5}};
      end
      if (in_valid && in_ready) kk++;
      cyc++;
      @(negedge clk);
      if (done) dones++;
    end
    in_valid = 1'b0;
    check($sformatf("v%0d_load_beats", vi), kk, v.k);
    if (v.k > 0) begin
      check($sformatf("v%0d_in_ready_flush", vi), in_ready, 0);
      check($sformatf("v%0d_busy_flush", vi), busy, 1);
    end
    t = 1;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      if (done) dones++;
      t++;
    end
    check($sformatf("v%0d_latency", vi), t, (v.k == 0) ? 1 : R + C - 1);
    beats = 0;
    cyc = 0;
    stalled = 1'b0;
    while (beats < R && cyc < 200) begin
      if (v.k == 0) begin
        start = 1'b1;
        k_len = KW'(3);
      end
      out_ready = v.stall ? (cyc % 2 == 1) : 1'b1;
      if (stalled) begin
        check($sformatf("v%0d_stall_data", vi), (out_data == held_d), 1);
        check($sformatf("v%0d_stall_row", vi), out_row, held_r);
      end
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        check($sformatf("v%0d_row_order", vi), out_row, beats);
        check($sformatf("v%0d_last_r%0d", vi, beats), out_last, (beats == R - 1));
        if (v.stall) check($sformatf("v%0d_in_ready_drain", vi), in_ready, 0);
        for (int c = 0; c < C; c++) got[beats][c] = int'($signed(out_data[c*AW +: AW]));
        beats++;
        if (beats == R) start = 1'b0;
      end else if (out_valid) begin
        held_d = out_data;
        held_r = out_row;
        stalled = 1'b1;
      end
      cyc++;
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check($sformatf("v%0d_drain_beats", vi), beats, R);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check($sformatf("v%0d_done_pulses", vi), dones, 1);
    check($sformatf("v%0d_idle_after", vi), busy, 0);
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        check($sformatf("v%0d_elem_r%0d_c%0d", vi, r, c), got[r][c], int'($signed(v.exp[r*C+c])));
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_out_data"}, (out_data == '0), 1);
    check({tag, "_out_row"}, out_row, 0);
  endtask

  int t2 [16] = '{2, 4, 6, 8, 4, 8, 12, 16, 6, 12, 18, 24, 8, 16, 24, 32};
  int t6 [16] = '{14, 20, 26, 32, 20, 29, 38, 47, 26, 38, 50, 62, 32, 47, 62, 77};

  initial begin
    int dones;
    reset_n = 1'b0;
    start = 1'b0;
    k_len = '0;
    in_valid = 1'b0;
    in_data = '0;
    wt_data = '0;
    out_ready = 1'b0;

    vecs[0] = '{k:3,   a0:1,    ar:0, ak:0, w0:1,   wc:0, wk:0, bub:0, stall:0, exp:'0};
    vecs[1] = '{k:4,   a0:-2,   ar:0, ak:0, w0:3,   wc:0, wk:0, bub:0, stall:0, exp:'0};
    vecs[2] = '{k:2,   a0:1,    ar:1, ak:0, w0:1,   wc:1, wk:0, bub:0, stall:0, exp:'0};
    vecs[3] = '{k:2,   a0:1,    ar:1, ak:0, w0:1,   wc:1, wk:0, bub:1, stall:1, exp:'0};
    vecs[4] = '{k:0,   a0:7,    ar:0, ak:0, w0:7,   wc:0, wk:0, bub:0, stall:1, exp:'0};
    vecs[5] = '{k:255, a0:-128, ar:0, ak:0, w0:127, wc:0, wk:0, bub:0, stall:0, exp:'0};
    vecs[6] = '{k:3,   a0:1,    ar:1, ak:1, w0:1,   wc:1, wk:1, bub:1, stall:0, exp:'0};
    for (int i = 0; i < R*C; i++) begin
      vecs[0].exp[i] = 32'd3;
      vecs[1].exp[i] = 32'hFFFF_FFE8;
      vecs[2].exp[i] = t2[i];
      vecs[3].exp[i] = t2[i];
      vecs[4].exp[i] = 32'd0;
      vecs[5].exp[i] = -32'sd4145280;
      vecs[6].exp[i] = t6[i];
    end

    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_tile(i);

    // Reset mid-LOAD abandons the tile silently.
    dones = 0;
    start = 1'b1;
    k_len = KW'(3);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    drive_beat(vecs[0], 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_zero_outputs("rst_load");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rst_load_no_done", dones, 0);

    // Reset mid-DRAIN after one accepted beat.
    start = 1'b1;
    k_len = KW'(3);
    @(negedge clk);
    start = 1'b0;
    for (int kk = 0; kk < 3; kk++) begin
      in_valid = 1'b1;
      drive_beat(vecs[0], kk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("rst_drain_reached", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rst_drain_row1", out_row, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_zero_outputs("rst_drain");
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rst_drain_no_done", dones, 0);

    run_tile(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
